inst_prefetch_queue: RTL
========================

// Module: inst_prefetch_queue
//
// PURPOSE
//   Parametrised instruction register and prefetch queue. It sits between instruction
//   memory and the decoder, replacing the single-entry instruction register.
//   It buffers up to DEPTH fetched instruction words, each with its fetch PC, and uses
//   valid/ready handshakes on both sides. A synchronous flush discards all
//   queued words when a branch is taken.
//
// PARAMETERS
//   WIDTH  16  instruction word width in bits
//   PC_W   16  width of the PC tag stored with each word
//   DEPTH  4   number of queue entries; power of two, >= 2
//   CNT_W  $clog2(DEPTH)+1  width of the occupancy count (derived, do not override)
//
// PORTS
//   p2          in   1      clock; all state updates on rising edge
//   reset       in   1      asynchronous, active-low reset
//   flush       in   1      synchronous discard of all queued entries
//   mem_valid   in   1      mem_inst/mem_pc hold a fetched word
//   mem_inst    in   WIDTH  fetched instruction word
//   mem_pc      in   PC_W   PC of the fetched word
//   mem_ready   out  1      queue can accept a word this cycle
//   dec_valid   out  1      dec_inst/dec_pc hold the oldest queued word
//   dec_inst    out  WIDTH  oldest queued instruction word
//   dec_pc      out  PC_W   PC of dec_inst
//   dec_ready   in   1      decoder consumes the head word this cycle
//   count       out  CNT_W  current occupancy, 0..DEPTH
//   stall_cycles out 16     decoder-starved cycle counter (IPQ_STATS_EN only)
//
// BEHAVIOUR
//   - Reset (reset==0, asynchronous): wr_ptr=rd_ptr=0, count=0, all storage zeroed.
//     Resulting outputs: mem_ready=1, dec_valid=0, dec_inst=0, dec_pc=0, stall_cycles=0.
//   - Derived outputs, all from registered state only (no input-to-output comb path):
//     - mem_ready = (count != DEPTH)
//     - dec_valid = (count != 0)
//     - dec_inst/dec_pc = storage[rd_ptr] when dec_valid, otherwise forced to 0.
//   - Transfers:
//     - push = mem_valid & mem_ready: writes storage[wr_ptr], then wr_ptr+1.
//     - pop = dec_valid & dec_ready: increments rd_ptr.
//   - Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
//   - count update: count + push - pop. Simultaneous push and pop leaves count unchanged.
//     This case is legal at any occupancy 1..DEPTH-1.
//   - Full (count==DEPTH): mem_ready=0, so a push is impossible. A pop in that cycle
//     makes mem_ready=1 the following cycle (no same-cycle pass-through).
//   - Empty (count==0): a pop is impossible. A push at edge N gives dec_valid=1 with
//     that word after edge N. Latency is 1 cycle.
//   - FIFO order is strict, and each word keeps its PC tag.
//   - flush=1 at an edge takes priority over push and pop:
//     - rd_ptr=wr_ptr=0 and count=0.
//     - Any push or pop in that cycle is discarded.
//     - Storage is not cleared; outputs are zero through the dec_valid=0 forcing.
//   - flush while empty is a no-op apart from zeroing the pointers.
//   - reset asserted mid-operation discards all entries immediately (asynchronous).
//     Operation resumes on the first p2 edge after reset deasserts.
//
// CONFIGURATION
//   IPQ_STATS_EN defined:
//     - Port stall_cycles exists: a 16-bit register.
//     - It increments on each edge where dec_ready=1, dec_valid=0 and flush=0.
//     - It saturates at 16'hFFFF and is cleared only by reset.
//   IPQ_STATS_EN undefined: port stall_cycles and its register are absent. All other
//     behaviour is identical.
//
// TESTING
//   1. Reset then idle: mem_ready=1, dec_valid=0, dec_inst=0, dec_pc=0, count=0.
//   2. Fill and drain:
//      - Push 16'hA001..16'hA004 with PCs 0..3 while dec_ready=0: count=4, mem_ready=0.
//      - A 5th push (16'hA005) is not accepted.
//      - Set dec_ready=1: A001..A004 come out in order with PCs 0..3, then dec_valid=0.
//   3. Streaming with mem_valid=dec_ready=1 for 20 cycles after 1 word is preloaded:
//      count stays 1, words leave in order, and the pointers wrap cleanly.
//   4. Flush with count=3 and a simultaneous push of 16'hBEEF: next cycle count=0,
//      dec_valid=0. Then push 16'h1234: it is the head word, not BEEF.
//   5. Pull reset low mid-stream with count=2, between edges: outputs go to reset
//      values without a clock edge. After release the first push has 1-cycle latency.
//   6. IPQ_STATS_EN: hold dec_ready=1 with the queue empty for 5 cycles, so
//      stall_cycles=5. A forced value of 16'hFFFE saturates at 16'hFFFF after 2 more
//      starved cycles.

Source files
------------

// File: rtl/inst_prefetch_queue.sv
// Instruction register / prefetch queue between instruction memory and decoder.
// Optional stall statistics counter enabled by defining IPQ_STATS_EN.
module inst_prefetch_queue #(
  parameter int WIDTH = 16,
  parameter int PC_W  = 16,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             p2,
  input  logic             reset,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic [WIDTH-1:0] mem_inst,
  input  logic [PC_W-1:0]  mem_pc,
  output logic             mem_ready,
  output logic             dec_valid,
  output logic [WIDTH-1:0] dec_inst,
  output logic [PC_W-1:0]  dec_pc,
  input  logic             dec_ready,
  output logic [CNT_W-1:0] count
`ifdef IPQ_STATS_EN
  ,
  output logic [15:0]      stall_cycles
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] inst_mem [DEPTH];
  logic [PC_W-1:0]  pc_mem   [DEPTH];
  logic             push;
  logic             pop;

  // All outputs are decoded from registered state; no input reaches an output.
  assign mem_ready = (count_reg != CNT_W'(DEPTH));
  assign dec_valid = (count_reg != '0);
  assign dec_inst  = dec_valid ? inst_mem[rd_ptr_reg] : '0;
  assign dec_pc    = dec_valid ? pc_mem[rd_ptr_reg] : '0;
  assign count     = count_reg;

  assign push = mem_valid & mem_ready;
  assign pop  = dec_valid & dec_ready;

  always_ff @(posedge p2 or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage survives a flush; stale words are hidden by the dec_valid forcing.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge p2 or negedge reset) begin
        if (!reset) begin
          inst_mem[gi] <= '0;
          pc_mem[gi]   <= '0;
        end else if (!flush && push && (wr_ptr_reg == PTR_W'(gi))) begin
          inst_mem[gi] <= mem_inst;
          pc_mem[gi]   <= mem_pc;
        end
      end
    end
  endgenerate

`ifdef IPQ_STATS_EN
  logic [15:0] stall_cycles_reg;

  always_ff @(posedge p2 or negedge reset) begin
    if (!reset) begin
      stall_cycles_reg <= '0;
    end else if (dec_ready && !dec_valid && !flush && (stall_cycles_reg != 16'hFFFF)) begin
      stall_cycles_reg <= stall_cycles_reg + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
`endif

endmodule
